// File: rtl/axis_downsizer.sv
// axis_downsizer: AXI-Stream width converter that splits one wide word of
// N*W bits into N narrow beats of W bits. The most-significant slice is sent
// first. Trailing beats beyond in_tkeep are trimmed, and tlast is carried
// onto the final kept beat.
//
// Ports
//   aclk, areset          clock; synchronous active-high reset
//   in_tdata  [N*W-1:0]   wide word; beat k = bits [(N-k)*W-1 : (N-k-1)*W]
//   in_tkeep  [N-1:0]     per-beat keep, contiguous from bit 0
//   in_tlast              wide word closes a packet
//   in_tvalid / in_tready wide-side handshake
//   out_tdata [W-1:0]     current narrow beat
//   out_tlast             beat closes a packet
//   out_tvalid / out_tready narrow-side handshake
module axis_downsizer #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic [N*W-1:0] in_tdata,
  input  logic [N-1:0]   in_tkeep,
  input  logic           in_tlast,
  input  logic           in_tvalid,
  output logic           in_tready,
  output logic [W-1:0]   out_tdata,
  output logic           out_tlast,
  output logic           out_tvalid,
  input  logic           out_tready
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW = N * W;

  logic [DW-1:0] buf_data_q, buf_data_d;
  logic          buf_last_q, buf_last_d;
  logic          buf_valid_q, buf_valid_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_idx_q, last_idx_d;

  logic          at_last;
  logic          accept;
  logic [IW:0]   keep_cnt;
  logic [IW-1:0] keep_last_idx;

  // Keep is contiguous from bit 0, so the final kept beat is popcount-1.
  always_comb begin
    keep_cnt = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (in_tkeep[k]) keep_cnt = keep_cnt + (IW+1)'(1);
    end
    keep_last_idx = IW'(keep_cnt - (IW+1)'(1));
  end

  assign at_last   = (idx_q == last_idx_q);
  // The only combinational path from an input to an output.
  assign in_tready = ~buf_valid_q | (out_tready & at_last);
  assign accept    = in_tvalid & in_tready;

  // Outputs are driven from the registers only.
  assign out_tvalid = buf_valid_q;
  assign out_tlast  = buf_valid_q & buf_last_q & at_last;

  always_comb begin
    out_tdata = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (idx_q == IW'(k)) out_tdata = buf_data_q[(int'(N)-1-k)*int'(W) +: W];
    end
  end

  // Next-state: advance the beat, retire the word, then let a capture override both.
  always_comb begin
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    buf_valid_d = buf_valid_q;
    idx_d       = idx_q;
    last_idx_d  = last_idx_q;

    if (buf_valid_q && out_tready) begin
      if (at_last) begin
        buf_valid_d = 1'b0;
        idx_d       = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    if (accept) begin
      buf_data_d  = in_tdata;
      buf_last_d  = in_tlast;
      buf_valid_d = 1'b1;
      idx_d       = '0;
      last_idx_d  = keep_last_idx;
    end
  end

  // Control state; reset wins over any handshake in the same cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      buf_valid_q <= 1'b0;
      buf_last_q  <= 1'b0;
      idx_q       <= '0;
      last_idx_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_last_q  <= buf_last_d;
      idx_q       <= idx_d;
      last_idx_q  <= last_idx_d;
    end
  end

  // Data buffer is qualified by buf_valid_q and needs no reset.
  always_ff @(posedge aclk) begin
    buf_data_q <= buf_data_d;
  end

  a_idx_in_range : assert property (@(posedge aclk) disable iff (areset)
    buf_valid_q |-> (idx_q <= last_idx_q));

  a_keep0_on_accept : assert property (@(posedge aclk) disable iff (areset)
    (in_tvalid && in_tready) |-> in_tkeep[0]);

  a_stall_stable : assert property (@(posedge aclk) disable iff (areset)
    (out_tvalid && !out_tready) |=>
      (out_tvalid && $stable(out_tdata) && $stable(out_tlast)));

endmodule
